match_ctrl: RTL and testbench
=============================

// Module: match_ctrl
// PURPOSE
//  Match sequencer for pong: owns the game state machine (attract, serve, rally, point pause, game over).
//  Sits beside game_logic and is clocked per frame by the display's new_frame pulse.
//  Gates ball physics (run_o), requests ball re-centering, and holds both scores and the winner.
//  The score outputs feed score_if.
// PARAMETERS
//  SCORE_W       4   width of each score counter
//  WIN_SCORE     9   points needed to win; must satisfy 1 <= WIN_SCORE < 2**SCORE_W
//  SERVE_FRAMES  60  frames the ball waits at centre before a rally starts (>=1)
//  POINT_FRAMES  90  frames of freeze after a point is scored (>=1)
// PORTS
//  clk_i        in   1        system clock
//  rst_i        in   1        synchronous reset, active-high
//  new_frame_i  in   1        one-cycle pulse, once per video frame
//  start_i      in   1        start key, level; rising edge detected internally
//  point_l_i    in   1        one-cycle pulse: left player scored (ball passed right edge)
//  point_r_i    in   1        one-cycle pulse: right player scored
//  ball_reset_o out  1        one-cycle pulse: centre ball and paddles
//  run_o        out  1        1 = physics advances this frame
//  serve_dir_o  out  1        0 = serve toward left, 1 = toward right
//  score_l_o    out  SCORE_W  left score
//  score_r_o    out  SCORE_W  right score
//  winner_o     out  2        00 none, 01 left, 10 right
//  state_o      out  3        IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4 PAUSE=5
// BEHAVIOUR
//  - All outputs are registered. Reset values: state IDLE, run 0, ball_reset 0, serve_dir 0, scores 0, winner 00.
//  - Frame counter fcnt counts new_frame_i pulses. It is cleared on every state entry.
//  - start_q holds the registered start_i. Start edge = start_i & ~start_q.
//  - IDLE: run 0. On a start edge, next cycle:
//    - clear scores and winner, serve_dir=0, pulse ball_reset_o, go to SERVE.
//  - SERVE: run 0. On new_frame_i with fcnt==SERVE_FRAMES-1, go to PLAY with run 1 in the same cycle.
//  - PLAY: run 1.
//    - On point_l_i: score_l+1, serve_dir=1, go to POINT, run 0. All updates land 1 cycle after the pulse.
//    - On point_r_i: the mirror case; serve_dir=0.
//    - If both pulses arrive in the same cycle, point_l_i wins and point_r_i is dropped.
//    - If the incremented score equals WIN_SCORE, go to OVER instead of POINT and set winner_o.
//  - POINT: run 0. On new_frame_i with fcnt==POINT_FRAMES-1, pulse ball_reset_o and go to SERVE.
//  - OVER: run 0. Scores and winner are held. A start edge behaves exactly as the IDLE start.
//  - point_*_i are ignored in every state except PLAY. Scores never exceed WIN_SCORE; there is no wrap.
//  - start_i is ignored outside IDLE and OVER.
//  - rst_i mid-match returns every output to its reset value at the next edge. A pending pulse is discarded.
//  - ball_reset_o is high for exactly one cycle per SERVE entry.
// CONFIGURATION
//  MATCH_CTRL_PAUSE_EN defined:
//   - Adds port pause_i (in, 1, level); its rising edge is detected internally.
//   - In SERVE or PLAY, a pause edge saves the current state and enters PAUSE.
//   - In PAUSE: run 0, fcnt frozen, point_*_i ignored.
//   - A pause edge in PAUSE restores the saved state. fcnt is kept, and run is restored if the saved state is PLAY.
//   - Pause edges in other states are ignored.
//  MATCH_CTRL_PAUSE_EN undefined: pause_i is absent, and state 5 is never produced.
// TESTING (WIN_SCORE=3, SERVE_FRAMES=2, POINT_FRAMES=3)
//  1. Reset, then a start edge -> state 1, ball_reset pulse of 1 cycle, scores 0.
//     Then 2 new_frame pulses -> state 2, run_o=1.
//  2. In PLAY, point_l pulse -> next cycle score_l=1, serve_dir=1, state 3, run 0.
//     Then 3 frames -> ball_reset pulse, state 1.
//  3. point_l and point_r in the same cycle -> score_l+1, score_r unchanged.
//     Point pulses in SERVE or POINT -> no score change.
//  4. Three left points -> score_l=3, winner=01, state 4.
//     Further points are ignored. A start edge -> scores 0, winner 00, state 1.
//  5. rst_i asserted mid-POINT with fcnt=1 -> next cycle all outputs equal their reset values.
//     A held start_i produces no start edge until it is released and pressed again.
//  6. (PAUSE_EN) Pause in PLAY -> state 5, run 0, point ignored.
//     A second pause edge -> state 2, run 1, scores unchanged.

Source files
------------

// File: rtl/match_ctrl.sv
// match_ctrl -- pong match sequencer.
// Owns the game state machine (attract, serve, rally, point pause, game over),
// gates ball physics, requests ball re-centering and holds both scores and the
// winner. Time inside a state is counted in video frames (new_frame_i pulses).
//
// Optional feature macro: MATCH_CTRL_PAUSE_EN adds pause_i and the PAUSE state.
//
// Ports
//   clk_i, rst_i   clock, synchronous active-high reset
//   new_frame_i    one-cycle pulse per video frame
//   start_i        start key level (rising edge detected here)
//   point_l_i/_r_i one-cycle pulse: left / right player scored
//   pause_i        pause key level (only with MATCH_CTRL_PAUSE_EN)
//   ball_reset_o   one-cycle pulse on every SERVE entry
//   run_o          physics enable
//   serve_dir_o    0 = serve toward left, 1 = toward right
//   score_l_o/_r_o scores
//   winner_o       00 none, 01 left, 10 right
//   state_o        IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4 PAUSE=5
module match_ctrl #(
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               new_frame_i,
  input  logic               start_i,
  input  logic               point_l_i,
  input  logic               point_r_i,
`ifdef MATCH_CTRL_PAUSE_EN
  input  logic               pause_i,
`endif
  output logic               ball_reset_o,
  output logic               run_o,
  output logic               serve_dir_o,
  output logic [SCORE_W-1:0] score_l_o,
  output logic [SCORE_W-1:0] score_r_o,
  output logic [1:0]         winner_o,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4,
    PAUSE = 3'd5
  } state_t;

  localparam int FMAX   = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int FCNT_W = (FMAX > 1) ? $clog2(FMAX) : 1;

  localparam logic [FCNT_W-1:0]  SERVE_LAST = FCNT_W'(SERVE_FRAMES - 1);
  localparam logic [FCNT_W-1:0]  POINT_LAST = FCNT_W'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

  state_t              state;
  logic [FCNT_W-1:0]   fcnt;
  logic                start_q;
  logic                start_edge;
  logic [SCORE_W-1:0]  inc_l, inc_r;

  assign start_edge = start_i & ~start_q;
  assign inc_l      = score_l_o + 1'b1;
  assign inc_r      = score_r_o + 1'b1;
  assign state_o    = state;

`ifdef MATCH_CTRL_PAUSE_EN
  state_t saved;
  logic   pause_q;
  logic   pause_edge;
  assign pause_edge = pause_i & ~pause_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      run_o        <= 1'b0;
      ball_reset_o <= 1'b0;
      serve_dir_o  <= 1'b0;
      score_l_o    <= '0;
      score_r_o    <= '0;
      winner_o     <= 2'b00;
      fcnt         <= '0;
      // Track the key during reset so a key held through reset is not
      // mistaken for a fresh press.
      start_q      <= start_i;
`ifdef MATCH_CTRL_PAUSE_EN
      pause_q      <= pause_i;
      saved        <= IDLE;
`endif
    end else begin
      start_q      <= start_i;
      ball_reset_o <= 1'b0;
`ifdef MATCH_CTRL_PAUSE_EN
      pause_q      <= pause_i;
`endif
      case (state)
        IDLE, OVER: begin
          run_o <= 1'b0;
          if (start_edge) begin
            score_l_o    <= '0;
            score_r_o    <= '0;
            winner_o     <= 2'b00;
            serve_dir_o  <= 1'b0;
            ball_reset_o <= 1'b1;
            fcnt         <= '0;
            state        <= SERVE;
          end
        end

        SERVE: begin
`ifdef MATCH_CTRL_PAUSE_EN
          // fcnt is left alone so the serve countdown resumes where it stopped.
          if (pause_edge) begin
            saved <= SERVE;
            state <= PAUSE;
            run_o <= 1'b0;
          end else
`endif
          if (new_frame_i) begin
            if (fcnt == SERVE_LAST) begin
              fcnt  <= '0;
              run_o <= 1'b1;
              state <= PLAY;
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
        end

        PLAY: begin
`ifdef MATCH_CTRL_PAUSE_EN
          if (pause_edge) begin
            saved <= PLAY;
            state <= PAUSE;
            run_o <= 1'b0;
          end else
`endif
          // Left takes priority when both pulses coincide; right is dropped.
          if (point_l_i) begin
            score_l_o   <= inc_l;
            serve_dir_o <= 1'b1;
            run_o       <= 1'b0;
            fcnt        <= '0;
            if (inc_l == WIN) begin
              winner_o <= 2'b01;
              state    <= OVER;
            end else begin
              state <= POINT;
            end
          end else if (point_r_i) begin
            score_r_o   <= inc_r;
            serve_dir_o <= 1'b0;
            run_o       <= 1'b0;
            fcnt        <= '0;
            if (inc_r == WIN) begin
              winner_o <= 2'b10;
              state    <= OVER;
            end else begin
              state <= POINT;
            end
          end
        end

        POINT: begin
          run_o <= 1'b0;
          if (new_frame_i) begin
            if (fcnt == POINT_LAST) begin
              fcnt         <= '0;
              ball_reset_o <= 1'b1;
              state        <= SERVE;
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
        end

`ifdef MATCH_CTRL_PAUSE_EN
        PAUSE: begin
          run_o <= 1'b0;
          if (pause_edge) begin
            state <= saved;
            run_o <= (saved == PLAY);
          end
        end
`endif

        default: begin
          run_o <= 1'b0;
          fcnt  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl with WIN_SCORE=3, SERVE_FRAMES=2, POINT_FRAMES=3.
// Each step drives one cycle of inputs and queues the outputs expected after
// the next rising edge; the queue head is popped and compared 1 ns later.
module tb_match_ctrl;

  localparam int SW = 4;

  typedef struct packed {
    logic [2:0]    state;
    logic          run;
    logic          br;
    logic          sd;
    logic [SW-1:0] sl;
    logic [SW-1:0] sr;
    logic [1:0]    win;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          nf = 1'b0, st = 1'b0, pl = 1'b0, pr = 1'b0;
  logic          ps = 1'b0;
  logic          ball_reset, run, serve_dir;
  logic [SW-1:0] score_l, score_r;
  logic [1:0]    winner;
  logic [2:0]    state;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  match_ctrl #(
    .SCORE_W(SW), .WIN_SCORE(3), .SERVE_FRAMES(2), .POINT_FRAMES(3)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .new_frame_i(nf),
    .start_i(st),
    .point_l_i(pl),
    .point_r_i(pr),
`ifdef MATCH_CTRL_PAUSE_EN
    .pause_i(ps),
`endif
    .ball_reset_o(ball_reset),
    .run_o(run),
    .serve_dir_o(serve_dir),
    .score_l_o(score_l),
    .score_r_o(score_r),
    .winner_o(winner),
    .state_o(state)
  );

  task automatic chk(input string tag, input int step_no, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s step %0d: got %0h want %0h", tag, step_no, obs, expv);
    end
  endtask

  // One cycle: drive inputs, push expectation, clock, pop and compare.
  task automatic step(input int n, input logic r, input logic f, input logic s,
                      input logic l, input logic rr, input logic p,
                      input logic [2:0] e_st, input logic e_run, input logic e_br,
                      input logic e_sd, input int e_sl, input int e_sr, input logic [1:0] e_win);
    exp_t e, got;
    rst = r; nf = f; st = s; pl = l; pr = rr; ps = p;
    e = '{state: e_st, run: e_run, br: e_br, sd: e_sd,
          sl: SW'(e_sl), sr: SW'(e_sr), win: e_win};
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard step %0d: got empty queue want entry", n);
    end
    if (sb.size() != 0) begin
      got = sb.pop_front();
      chk("state",      n, 8'(state),      8'(got.state));
      chk("run",        n, 8'(run),        8'(got.run));
      chk("ball_reset", n, 8'(ball_reset), 8'(got.br));
      chk("serve_dir",  n, 8'(serve_dir),  8'(got.sd));
      chk("score_l",    n, 8'(score_l),    8'(got.sl));
      chk("score_r",    n, 8'(score_r),    8'(got.sr));
      chk("winner",     n, 8'(winner),     8'(got.win));
    end
  endtask

  initial begin
    #2;
    //   n  rst nf st pl pr ps   state run br sd sl sr win
    // reset
    step( 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 2'b00);
    step( 2, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 2'b00);
    // start edge -> SERVE with one-cycle ball_reset; held start is no new edge
    step( 3, 0, 0, 1, 0, 0, 0,   1, 0, 1, 0, 0, 0, 2'b00);
    step( 4, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 2'b00);
    // two frames -> PLAY
    step( 5, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 2'b00);
    step( 6, 0, 1, 0, 0, 0, 0,   2, 1, 0, 0, 0, 0, 2'b00);
    // left point
    step( 7, 0, 0, 0, 1, 0, 0,   3, 0, 0, 1, 1, 0, 2'b00);
    // point pulses in POINT are ignored; 3 frames -> SERVE
    step( 8, 0, 1, 0, 1, 0, 0,   3, 0, 0, 1, 1, 0, 2'b00);
    step( 9, 0, 1, 0, 0, 0, 0,   3, 0, 0, 1, 1, 0, 2'b00);
    step(10, 0, 0, 0, 0, 1, 0,   3, 0, 0, 1, 1, 0, 2'b00);
    step(11, 0, 1, 0, 0, 0, 0,   1, 0, 1, 1, 1, 0, 2'b00);
    // point in SERVE ignored
    step(12, 0, 0, 0, 1, 0, 0,   1, 0, 0, 1, 1, 0, 2'b00);
    step(13, 0, 1, 0, 0, 0, 0,   1, 0, 0, 1, 1, 0, 2'b00);
    step(14, 0, 1, 0, 0, 0, 0,   2, 1, 0, 1, 1, 0, 2'b00);
    // simultaneous points: left wins
    step(15, 0, 0, 0, 1, 1, 0,   3, 0, 0, 1, 2, 0, 2'b00);
    step(16, 0, 1, 0, 0, 0, 0,   3, 0, 0, 1, 2, 0, 2'b00);
    step(17, 0, 1, 0, 0, 0, 0,   3, 0, 0, 1, 2, 0, 2'b00);
    step(18, 0, 1, 0, 0, 0, 0,   1, 0, 1, 1, 2, 0, 2'b00);
    step(19, 0, 1, 0, 0, 0, 0,   1, 0, 0, 1, 2, 0, 2'b00);
    step(20, 0, 1, 0, 0, 0, 0,   2, 1, 0, 1, 2, 0, 2'b00);
    // right point: serve toward left
    step(21, 0, 0, 0, 0, 1, 0,   3, 0, 0, 0, 2, 1, 2'b00);
    step(22, 0, 1, 0, 0, 0, 0,   3, 0, 0, 0, 2, 1, 2'b00);
    step(23, 0, 1, 0, 0, 0, 0,   3, 0, 0, 0, 2, 1, 2'b00);
    step(24, 0, 1, 0, 0, 0, 0,   1, 0, 1, 0, 2, 1, 2'b00);
    step(25, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 2, 1, 2'b00);
    step(26, 0, 1, 0, 0, 0, 0,   2, 1, 0, 0, 2, 1, 2'b00);
    // third left point wins
    step(27, 0, 0, 0, 1, 0, 0,   4, 0, 0, 1, 3, 1, 2'b01);
    step(28, 0, 0, 0, 1, 1, 0,   4, 0, 0, 1, 3, 1, 2'b01);
    step(29, 0, 1, 0, 0, 0, 0,   4, 0, 0, 1, 3, 1, 2'b01);
    // restart from OVER
    step(30, 0, 0, 1, 0, 0, 0,   1, 0, 1, 0, 0, 0, 2'b00);
    step(31, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 2'b00);
    step(32, 0, 1, 0, 0, 0, 0,   2, 1, 0, 0, 0, 0, 2'b00);
    step(33, 0, 0, 0, 1, 0, 0,   3, 0, 0, 1, 1, 0, 2'b00);
    step(34, 0, 1, 0, 0, 0, 0,   3, 0, 0, 1, 1, 0, 2'b00);
    // reset mid-POINT (fcnt=1) with start held and a point pulse pending
    step(35, 1, 1, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 2'b00);
    step(36, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 2'b00);
    step(37, 0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 2'b00);
    step(38, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 2'b00);
    step(39, 0, 0, 1, 0, 0, 0,   1, 0, 1, 0, 0, 0, 2'b00);
    step(40, 0, 1, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 2'b00);
    step(41, 0, 1, 0, 0, 0, 0,   2, 1, 0, 0, 0, 0, 2'b00);
`ifdef MATCH_CTRL_PAUSE_EN
    // pause in PLAY, points ignored, frames frozen, second edge resumes
    step(42, 0, 0, 0, 1, 0, 1,   5, 0, 0, 0, 0, 0, 2'b00);
    step(43, 0, 0, 0, 1, 0, 1,   5, 0, 0, 0, 0, 0, 2'b00);
    step(44, 0, 1, 0, 0, 1, 0,   5, 0, 0, 0, 0, 0, 2'b00);
    step(45, 0, 0, 0, 0, 0, 1,   2, 1, 0, 0, 0, 0, 2'b00);
    step(46, 0, 0, 0, 0, 1, 0,   3, 0, 0, 0, 0, 1, 2'b00);
    // pause in POINT is ignored
    step(47, 0, 0, 0, 0, 0, 0,   3, 0, 0, 0, 0, 1, 2'b00);
    step(48, 0, 0, 0, 0, 0, 1,   3, 0, 0, 0, 0, 1, 2'b00);
`else
    // without the pause feature points keep working in PLAY
    step(42, 0, 0, 0, 0, 1, 1,   3, 0, 0, 0, 0, 1, 2'b00);
`endif
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard drain: got %0d entries want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
